// File: rtl/stepper_move_scheduler_pkg.sv
// Shared types for the stepper move scheduler: FSM state encoding and
// direction constants used by the scheduler and its bench.
package stepper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_STEP,
    ST_FINISH
  } sched_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

endpackage

// File: rtl/step_interval_timer.sv
// Loadable down-counter shared by the settle delay and the step period.
// expire is high for the single cycle in which the count reads 1.
module step_interval_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         clear,
  output logic         expire
);

  logic [W-1:0] count;

  // load beats the idle decrement so an expiring interval can chain straight into the next
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/stepper_move_scheduler.sv
// Move scheduler for one stepper channel: accepts (dir, steps) moves, emits
// rotate_pulse toggles on a trapezoidal period ramp and tracks position.
module stepper_move_scheduler
  import stepper_pkg::*;
#(
  parameter int STEPS_W       = 16,
  parameter int PERIOD_W      = 24,
  parameter int POS_W         = 32,
  parameter int SETTLE_CYCLES = 27000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [STEPS_W-1:0]      cmd_steps,
  input  logic [PERIOD_W-1:0]     cfg_start_period,
  input  logic [PERIOD_W-1:0]     cfg_min_period,
  input  logic [PERIOD_W-1:0]     cfg_accel,
  input  logic                    abort,
  output logic                    rotate_pulse,
  output logic                    direction,
  output logic                    module_enable,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic signed [POS_W-1:0] position,
  output sched_state_t            dbg_state
);

  localparam logic [PERIOD_W-1:0] ONE_P       = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] SETTLE_LOAD = PERIOD_W'(SETTLE_CYCLES);
  localparam logic [POS_W-1:0]    POS_INC     = POS_W'(1);
  localparam logic [POS_W-1:0]    POS_DEC     = '1;

  sched_state_t state, next_state;

  logic [PERIOD_W-1:0] cur_period, start_q, min_q, accel_q;
  logic [PERIOD_W-1:0] start_eff, min_floor, min_eff, cur_next, tmr_value;
  logic [PERIOD_W:0]   up_sum, dn_diff;
  logic [STEPS_W-1:0]  remaining, ramp, rem_dec, ramp_next;
  logic                aborted_q;
  logic                accept, needs_settle, abort_hit, step_fire;
  logic                tmr_load, tmr_clear, tmr_expire;

  // Handshake: a command transfers on any cycle with cmd_valid && cmd_ready; ready is
  // high in IDLE and FINISH (never during reset) and cmd_*/cfg_* are captured at that edge.
  assign cmd_ready    = !reset && (state == ST_IDLE || state == ST_FINISH);
  assign accept       = cmd_valid && cmd_ready;
  assign needs_settle = !module_enable || (direction != cmd_dir);
  assign abort_hit    = abort && (state == ST_SETTLE || state == ST_STEP);
  assign step_fire    = (state == ST_STEP) && tmr_expire && !abort;
  assign busy         = (state == ST_SETTLE || state == ST_STEP);
  assign done         = (state == ST_FINISH);
  assign aborted      = done && aborted_q;
  assign dbg_state    = state;

  // Effective period bounds: zero start acts as 1, and a floor above start pins to start.
  always_comb begin
    start_eff = (cfg_start_period == '0) ? ONE_P : cfg_start_period;
    min_floor = (cfg_min_period == '0) ? ONE_P : cfg_min_period;
    min_eff   = (min_floor > start_eff) ? start_eff : min_floor;
  end

  // Ramp update evaluated against the post-step remaining count; one spare bit avoids wrap.
  always_comb begin
    rem_dec   = remaining - STEPS_W'(1);
    up_sum    = {1'b0, cur_period} + {1'b0, accel_q};
    dn_diff   = {1'b0, cur_period} - {1'b0, accel_q};
    cur_next  = cur_period;
    ramp_next = ramp;
    if (rem_dec <= ramp) begin
      cur_next  = (up_sum > {1'b0, start_q}) ? start_q : up_sum[PERIOD_W-1:0];
      ramp_next = (ramp == '0) ? '0 : ramp - STEPS_W'(1);
    end else if (cur_period > min_q) begin
      cur_next  = (dn_diff[PERIOD_W] || dn_diff[PERIOD_W-1:0] < min_q) ? min_q
                                                                       : dn_diff[PERIOD_W-1:0];
      ramp_next = ramp + STEPS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_clear  = 1'b0;
    tmr_value  = cur_period;
    case (state)
      ST_IDLE, ST_FINISH: begin
        next_state = ST_IDLE;
        if (accept) begin
          if (cmd_steps == '0) begin
            next_state = ST_FINISH;
          end else begin
            next_state = needs_settle ? ST_SETTLE : ST_STEP;
            tmr_load   = 1'b1;
            tmr_value  = needs_settle ? SETTLE_LOAD : start_eff;
          end
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          next_state = ST_FINISH;
          tmr_clear  = 1'b1;
        end else if (tmr_expire) begin
          next_state = ST_STEP;
          tmr_load   = 1'b1;
        end
      end
      ST_STEP: begin
        if (abort) begin
          next_state = ST_FINISH;
          tmr_clear  = 1'b1;
        end else if (tmr_expire) begin
          if (rem_dec == '0) begin
            next_state = ST_FINISH;
          end else begin
            tmr_load  = 1'b1;
            tmr_value = cur_next;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rotate_pulse  <= 1'b0;
      direction     <= DIR_FWD;
      module_enable <= 1'b0;
      position      <= '0;
      aborted_q     <= 1'b0;
      cur_period    <= '0;
      start_q       <= '0;
      min_q         <= '0;
      accel_q       <= '0;
      remaining     <= '0;
      ramp          <= '0;
    end else if (accept) begin
      aborted_q <= 1'b0;
      if (cmd_steps != '0) begin
        direction     <= cmd_dir;
        module_enable <= 1'b1;
        cur_period    <= start_eff;
        start_q       <= start_eff;
        min_q         <= min_eff;
        accel_q       <= cfg_accel;
        remaining     <= cmd_steps;
        ramp          <= '0;
      end
    end else if (abort_hit) begin
      module_enable <= 1'b0;
      aborted_q     <= 1'b1;
    end else if (step_fire) begin
      rotate_pulse <= ~rotate_pulse;
      position     <= position + ((direction == DIR_FWD) ? POS_INC : POS_DEC);
      remaining    <= rem_dec;
      cur_period   <= cur_next;
      ramp         <= ramp_next;
    end else if (abort && state == ST_IDLE) begin
      module_enable <= 1'b0;
    end
  end

  step_interval_timer #(.W(PERIOD_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .clear      (tmr_clear),
    .expire     (tmr_expire)
  );

endmodule

// File: tb/tb_stepper_move_scheduler.sv
// Directed bench for stepper_move_scheduler: ramp profile, zero-step, back-to-back,
// reversal, abort, period clamping, position wrap and mid-move reset.
module tb_stepper_move_scheduler;
  import stepper_pkg::*;

  localparam int S = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_dir;
  logic [15:0]  cmd_steps;
  logic [23:0]  cfg_start_period;
  logic [23:0]  cfg_min_period;
  logic [23:0]  cfg_accel;
  logic         abort;
  logic         rotate_pulse;
  logic         direction;
  logic         module_enable;
  logic         busy;
  logic         done;
  logic         aborted;
  logic [7:0]   pos;
  sched_state_t dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int tog_cyc[$];
  logic [31:0] exp_q[$];
  logic prev_rp = 1'b0;

  stepper_move_scheduler #(
    .STEPS_W(16), .PERIOD_W(24), .POS_W(8), .SETTLE_CYCLES(S)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_dir          (cmd_dir),
    .cmd_steps        (cmd_steps),
    .cfg_start_period (cfg_start_period),
    .cfg_min_period   (cfg_min_period),
    .cfg_accel        (cfg_accel),
    .abort            (abort),
    .rotate_pulse     (rotate_pulse),
    .direction        (direction),
    .module_enable    (module_enable),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted),
    .position         (pos),
    .dbg_state        (dbg_state)
  );

  // ---- clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // toggle and done monitor, sampled 1 time unit after each edge
  always @(posedge clk) begin
    #1;
    if (rotate_pulse !== prev_rp) tog_cyc.push_back(cyc);
    prev_rp = rotate_pulse;
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic dir, input int steps, input int sp, input int mp,
                      input int ac, output int acc);
    cmd_dir          = dir;
    cmd_steps        = steps[15:0];
    cfg_start_period = sp[23:0];
    cfg_min_period   = mp[23:0];
    cfg_accel        = ac[23:0];
    cmd_valid        = 1'b1;
    acc = -1;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      if (cmd_ready === 1'b1) begin
        tick();
        acc = cyc;
      end else begin
        tick();
      end
    end
    cmd_valid = 1'b0;
    chk("accept_seen", acc >= 0, 1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget && dc < 0; i++) begin
      tick();
      if (done === 1'b1) dc = cyc;
    end
    chk({tag, "_done_seen"}, dc >= 0, 1);
  endtask

  // ---- scoreboard: compare toggle spacing against exp_q, starting from ref_cyc
  task automatic check_intervals(input string tag, input int ref_cyc);
    int prev;
    logic [31:0] e;
    chk({tag, "_toggle_count"}, tog_cyc.size(), exp_q.size());
    prev = ref_cyc;
    for (int i = 0; i < tog_cyc.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_interval%0d", tag, i), tog_cyc[i] - prev, e);
      prev = tog_cyc[i];
    end
    exp_q.delete();
  endtask

  function automatic int last_tog();
    return (tog_cyc.size() > 0) ? tog_cyc[tog_cyc.size()-1] : -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tog_cyc.delete();
  endtask

  int acc, acc_b, dc, d0;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = DIR_REV; cmd_steps = '0;
    cfg_start_period = '0; cfg_min_period = '0; cfg_accel = '0; abort = 1'b0;

    // reset values, with a command presented during reset
    cmd_valid = 1'b1; cmd_steps = 16'd9;
    tick(); tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rotate", rotate_pulse, 0);
    chk("rst_direction", direction, 1);
    chk("rst_enable", module_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_position", pos, 0);
    cmd_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("rst_release_ready", cmd_ready, 1);
    chk("rst_release_busy", busy, 0);
    chk("rst_cmd_ignored", done_cnt, 0);
    tog_cyc.delete();

    // 1: trapezoid ramp with settle
    send(DIR_FWD, 6, 10, 4, 2, acc);
    chk("t1_busy", busy, 1);
    chk("t1_ready_low", cmd_ready, 0);
    chk("t1_enable", module_enable, 1);
    wait_done("t1", 300, dc);
    chk("t1_aborted", aborted, 0);
    chk("t1_done_after_last", dc, last_tog());
    chk("t1_position", pos, 6);
    exp_q = '{10, 8, 6, 4, 6, 8};
    check_intervals("t1", acc + S);
    tick();
    chk("t1_done_one_cycle", done, 0);
    chk("t1_hold_enable", module_enable, 1);
    tog_cyc.delete();

    // 2: zero-step move
    send(DIR_FWD, 0, 10, 4, 2, acc);
    chk("t2_done_t1", done, 1);
    chk("t2_busy", busy, 0);
    tick();
    chk("t2_no_toggle", tog_cyc.size(), 0);
    chk("t2_position", pos, 6);
    chk("t2_enable", module_enable, 1);

    // abort while idle drops enable without a done
    d0 = done_cnt;
    abort = 1'b1; tick(); abort = 1'b0; tick();
    chk("idle_abort_enable", module_enable, 0);
    chk("idle_abort_no_done", done_cnt, d0);

    // 3: back-to-back same direction
    do_reset();
    send(DIR_FWD, 3, 4, 4, 1, acc);
    wait_done("t3a", 200, dc);
    chk("t3a_position", pos, 3);
    tog_cyc.delete();
    send(DIR_FWD, 2, 4, 4, 1, acc_b);
    chk("t3b_accept_at_done", acc_b, dc + 1);
    wait_done("t3b", 200, dc);
    exp_q = '{4, 4};
    check_intervals("t3b", acc_b);
    chk("t3b_position", pos, 5);
    tog_cyc.delete();

    // 4: direction reversal forces settle
    send(DIR_REV, 4, 4, 4, 1, acc);
    chk("t4_direction", direction, 0);
    wait_done("t4", 200, dc);
    exp_q = '{4, 4, 4, 4};
    check_intervals("t4", acc + S);
    chk("t4_position", pos, 1);

    // 5: abort on the cycle the 4th toggle is due
    do_reset();
    send(DIR_FWD, 100, 3, 3, 1, acc);
    for (int i = 0; i < 100 && tog_cyc.size() < 3; i++) tick();
    chk("t5_three_toggles", tog_cyc.size(), 3);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_aborted", aborted, 1);
    chk("t5_enable", module_enable, 0);
    chk("t5_position", pos, 3);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_no_more_toggles", tog_cyc.size(), 3);
    chk("t5_busy", busy, 0);
    tog_cyc.delete();

    // 6: clamp to 1 and back to start
    send(DIR_FWD, 4, 5, 0, 10, acc);
    wait_done("t6", 200, dc);
    chk("t6_aborted", aborted, 0);
    exp_q = '{5, 1, 1, 5};
    check_intervals("t6", acc + S);
    chk("t6_position", pos, 7);

    // 6b: position wrap, with start period 0 acting as 1
    do_reset();
    send(DIR_REV, 1, 0, 0, 1, acc);
    wait_done("t6b", 100, dc);
    exp_q = '{1};
    check_intervals("t6b", acc + S);
    chk("t6b_position_max", pos, 255);
    send(DIR_FWD, 1, 2, 2, 1, acc);
    wait_done("t6c", 100, dc);
    chk("t6c_position_wrap", pos, 0);

    // 7: reset mid-move
    send(DIR_FWD, 10, 3, 3, 1, acc);
    for (int i = 0; i < 12; i++) tick();
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    chk("t7_rotate", rotate_pulse, 0);
    chk("t7_enable", module_enable, 0);
    chk("t7_busy", busy, 0);
    chk("t7_position", pos, 0);
    chk("t7_direction", direction, 1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t7_no_done", done_cnt, d0);
    chk("t7_ready", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
